// File: rtl/mul_share_arb.sv
// Shares one pipelined unsigned multiplier among NREQ requesters.
// A round-robin arbiter issues operands under a credit rule; a shift register
// carries each requester ID through the multiplier latency; products are
// collected in a result FIFO and returned on a valid/ready response port.
module mul_share_arb #(
  parameter int SIZE       = 4,
  parameter int NREQ       = 4,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*SIZE-1:0]       req_a,
  input  logic [NREQ*SIZE-1:0]       req_b,
  output logic [NREQ-1:0]            req_ready,
  output logic [SIZE-1:0]            mul_a,
  output logic [SIZE-1:0]            mul_b,
  input  logic [2*SIZE-1:0]          mul_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [2*SIZE-1:0]          rsp_data,
  output logic                       idle
);

  localparam int IDW = $clog2(NREQ);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + LAT + 1);
  localparam int EW  = IDW + 2*SIZE;
  localparam int unsigned NR = NREQ;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_SLOT = AW'(FIFO_DEPTH - 1);

  logic [IDW-1:0]     ptr;
  logic [LAT-1:0]     sr_vld;
  logic [LAT*IDW-1:0] sr_id;
  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]      fifo_head;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;
  logic [CW-1:0]      inflight_cnt;
  logic               can_issue;
  logic               gnt_found;
  logic [IDW-1:0]     gnt_id;
  logic [IDW-1:0]     idx;
  logic               issue;
  logic               wr_en;
  logic               rd_en;

  // Credit: operations in flight plus results waiting must fit in the FIFO.
  always_comb begin
    inflight_cnt = CW'($countones(sr_vld));
    can_issue    = (inflight_cnt + fifo_cnt) < DEPTH_C;
  end

  // Round-robin scan starting one past the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NR; k++) begin
      idx = IDW'((32'(ptr) + k) % NR);
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
    issue = rst_n && gnt_found && can_issue;
  end

  // Ready to the granted requester and its operands to the multiplier; zeros otherwise.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (issue && gnt_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[i*SIZE +: SIZE];
        mul_b        = req_b[i*SIZE +: SIZE];
      end
    end
  end

  // Round-robin pointer follows the last grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDW'(NREQ - 1);
    end else if (issue) begin
      ptr <= gnt_id;
    end
  end

  // Valid/ID shift register mirroring the multiplier pipeline; packed so the
  // shift is a truncating concatenation and works for any LAT >= 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_vld <= '0;
      sr_id  <= '0;
    end else begin
      sr_vld <= LAT'({sr_vld, issue});
      sr_id  <= (LAT*IDW)'({sr_id, (issue ? gnt_id : IDW'(0))});
    end
  end

  assign wr_en = sr_vld[LAT-1];
  assign rd_en = rsp_valid && rsp_ready;

  // Result FIFO storage; contents are meaningless unless counted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr] <= {sr_id[LAT*IDW-1 -: IDW], mul_out};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Response port shows the FIFO head, zeroed when empty.
  always_comb begin
    fifo_head = fifo_mem[rd_ptr];
    rsp_valid = (fifo_cnt != '0);
    rsp_id    = rsp_valid ? fifo_head[2*SIZE +: IDW] : '0;
    rsp_data  = rsp_valid ? fifo_head[2*SIZE-1:0]   : '0;
    idle      = (inflight_cnt == '0) && (fifo_cnt == '0);
  end

  // The credit rule must keep the FIFO from ever being written while full.
  assert property (@(posedge clk) disable iff (!rst_n) wr_en |-> (fifo_cnt != DEPTH_C));

endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined unsigned multiplier among NREQ requesters.
- Drives the multiplier operands and tracks each operation's requester ID through the multiplier latency.
- Captures products into a result FIFO and returns them with ID on a valid/ready response port.
- Sits between client blocks and the multiplier instance. The multiplier has no valid or stall, so this block owns all flow control.

Parameters:
- SIZE, 4, operand width in bits; product is 2*SIZE.
- NREQ, 4, number of requesters; must be 2 or more.
- LAT, 2, multiplier latency in clock edges from operand sample to product on mul_out.
- FIFO_DEPTH, 4, result FIFO entries; must be at least LAT.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NREQ, per-requester request valid.
- req_a, in, NREQ*SIZE, flattened operand A; requester i uses bits [i*SIZE +: SIZE].
- req_b, in, NREQ*SIZE, flattened operand B, same packing.
- req_ready, out, NREQ, per-requester accept; at most one bit high per cycle.
- mul_a, out, SIZE, operand A to multiplier.
- mul_b, out, SIZE, operand B to multiplier.
- mul_out, in, 2*SIZE, product from multiplier.
- rsp_valid, out, 1, response available.
- rsp_ready, in, 1, consumer accepts response.
- rsp_id, out, clog2(NREQ), requester index of the response.
- rsp_data, out, 2*SIZE, product.
- idle, out, 1, high when nothing is in flight and the FIFO is empty.

Behaviour:
- Reset (asynchronous, any time): clear the in-flight shift register and FIFO, and set the RR pointer to NREQ-1 so requester 0 has top priority.
  - Outputs during reset: req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, mul_a=0, mul_b=0, idle=1.
  - All in-flight operations are dropped and never reported.
- Credit: can_issue = (inflight_cnt + fifo_cnt) < FIFO_DEPTH.
  - inflight_cnt is the number of set bits in the LAT-deep valid shift register.
  - Both counts are the registered values at the start of the cycle.
- Grant (combinational):
  - The first requester with req_valid high, scanning cyclically from ptr+1.
  - req_ready[g]=1 only if can_issue; all other ready bits are 0.
- Operands:
  - mul_a and mul_b carry the granted requester's operands in the issue cycle.
  - Otherwise they are 0, so the multiplier idles on 0*0.
- Issue in cycle c (req_valid[g] and req_ready[g] at the edge ending c):
  - ptr <= g.
  - Shift stage 0 <= {1, g}.
  - Each stage k <= stage k-1 per edge.
  - Cycles with no issue shift in {0, 0}.
- Capture: when stage LAT-1 is valid during cycle c+LAT, write {id, mul_out} into the FIFO at the edge ending that cycle.
  - The credit rule guarantees the FIFO is never full on a write; this is an assertion.
- Response:
  - rsp_valid = FIFO non-empty.
  - rsp_id and rsp_data show the FIFO head when rsp_valid=1, and 0 when it is 0.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous write and pop in one cycle is legal and leaves fifo_cnt unchanged.
  - Write into an empty FIFO makes rsp_valid high the next cycle; there is no bypass.
- Latency: issue in cycle c gives rsp_valid in cycle c+LAT+1 at the earliest.
- Throughput: one issue per cycle while credit is available and rsp_ready stays high.
- Ordering: responses leave in issue order. The ID travels with the data; no reordering.
- Arithmetic: unsigned; full 2*SIZE product with no truncation.
- Requester rule: a requester holds req_valid, req_a and req_b stable until it sees ready. The arbiter does not check this.
- Pointer: the RR pointer wraps from NREQ-1 to 0 and does not change on cycles with no grant.
- idle = (inflight_cnt == 0) && (fifo_cnt == 0).

Test Plan:
- Single request:
  - Stimulus: requester 2 with a=3, b=5, valid in cycle 0, rsp_ready=1.
  - Response: req_ready[2]=1 in cycle 0; mul_a=3, mul_b=5 in cycle 0; rsp_valid in cycle 3 with id=2, data=15; idle returns to 1 in cycle 4.
- Round robin:
  - Stimulus: all 4 requesters held valid from reset with a=i+1, b=2.
  - Response: grants go 0,1,2,3,0 on consecutive cycles; responses in that order with data 2,4,6,8,2.
- Backpressure:
  - Stimulus: rsp_ready=0, requester 0 always valid with a=15, b=15.
  - Response: exactly 4 issues, then req_ready stays 0.
  - Release rsp_ready: 4 responses of 225, then issue resumes after the first pop.
- Simultaneous push and pop:
  - Stimulus: steady stream with rsp_ready=1.
  - Response: fifo_cnt stays stable and there is one response per cycle with no gaps after the pipeline fills.
- Reset mid-operation:
  - Stimulus: assert rst_n low one cycle after two issues.
  - Response: outputs zero immediately; no stale responses after release; first grant goes to requester 0.
- Boundary values:
  - Stimulus: a=0, b=15, then a=15, b=1.
  - Response: data 0, then 15, with correct IDs.
